tx_sequencer: RTL and testbench

TX_SEQUENCER -- requirements
Module: tx_sequencer

---
 rtl/tx_sequencer.sv | 114 +++++++++++
 tb/tb_tx_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tx_sequencer.sv
// tx_sequencer: round-robin word sequencer feeding bytes from four word ROMs to a serial transmitter.
// Optional TX_SEQ_TERMINATOR_EN appends a 0x0D byte after every word.
module tx_sequencer #(
  parameter int LEN0 = 11,
  parameter int LEN1 = 10,
  parameter int LEN2 = 7,
  parameter int LEN3 = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       auto_en,
  input  logic [7:0] rom_data,
  input  logic       tx_busy,
  output logic [1:0] rom_sel,
  output logic [3:0] rom_addr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       word_done
);
  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, WAIT_ACK, WAIT_DONE
`ifdef TX_SEQ_TERMINATOR_EN
    , TERM
`endif
  } state_t;
  state_t state_q, state_d;
  logic [3:0] pend_q, pend_d, len_sel;
  logic [1:0] last_q, last_d, sel_q, sel_d, gnt_idx;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic start_q, start_d, done_q, done_d, gnt_v, take, last_byte;
`ifdef TX_SEQ_TERMINATOR_EN
  logic term_q, term_d;
`endif
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      last_q  <= 2'd3;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_SEQ_TERMINATOR_EN
      term_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
`ifdef TX_SEQ_TERMINATOR_EN
      term_q  <= term_d;
`endif
    end
  end
  // Descending scan so the nearest pending word after last_q wins; auto cycling falls back to last_q+1.
  always_comb begin
    gnt_v   = auto_en;
    gnt_idx = last_q + 2'd1;
    for (int k = 4; k >= 1; k--)
      if (pend_q[2'(last_q + 2'(k))]) begin
        gnt_v   = 1'b1;
        gnt_idx = 2'(last_q + 2'(k));
      end
  end
  assign take      = (state_q == IDLE) && gnt_v;
  assign len_sel   = sel_q == 2'd0 ? 4'(LEN0) : sel_q == 2'd1 ? 4'(LEN1) : sel_q == 2'd2 ? 4'(LEN2) : 4'(LEN3);
  assign last_byte = addr_q == len_sel - 4'd1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = gnt_v ? FETCH : IDLE;
      FETCH:     state_d = SEND;
      SEND:      state_d = tx_busy ? SEND : WAIT_ACK;
      WAIT_ACK:  state_d = tx_busy ? WAIT_DONE : WAIT_ACK;
`ifdef TX_SEQ_TERMINATOR_EN
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : !last_byte ? FETCH : term_q ? IDLE : TERM;
      TERM:      state_d = SEND;
`else
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : last_byte ? IDLE : FETCH;
`endif
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    pend_d  = (pend_q & ~(take ? 4'd1 << gnt_idx : 4'd0)) | req;
    last_d  = take ? gnt_idx : last_q;
    sel_d   = take ? gnt_idx : sel_q;
    addr_d  = take ? 4'd0 : (state_q == WAIT_DONE && !tx_busy && !last_byte) ? addr_q + 4'd1 : addr_q;
    data_d  = state_q == FETCH ? rom_data : data_q;
    start_d = state_q == SEND && !tx_busy;
`ifdef TX_SEQ_TERMINATOR_EN
    data_d  = state_q == TERM ? 8'h0D : data_d;
    term_d  = state_q == TERM ? 1'b1 : state_q == IDLE ? 1'b0 : term_q;
    done_d  = state_q == WAIT_DONE && !tx_busy && last_byte && term_q;
`else
    done_d  = state_q == WAIT_DONE && !tx_busy && last_byte;
`endif
  end
  assign rom_sel   = sel_q;
  assign rom_addr  = addr_q;
  assign tx_data   = data_q;
  assign tx_start  = start_q;
  assign word_done = done_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_tx_sequencer.sv
// tb_tx_sequencer: directed checks of tx_sequencer against a 10-cycle transmitter model and a pattern ROM.
module tb_tx_sequencer;
`ifdef TX_SEQ_TERMINATOR_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif
  logic       sysclk = 1'b0, reset = 1'b0, auto_en = 1'b0, hold = 1'b0, mbusy = 1'b0;
  logic [3:0] req = 4'd0;
  logic       tx_busy, tx_start, busy, word_done;
  logic [7:0] rom_data, tx_data;
  logic [1:0] rom_sel;
  logic [3:0] rom_addr;
  logic [13:0] log_q[$];
  int cnt = 0, n_done = 0, n_cmp = 0, n_err = 0, base, t;
  int ws[5];

  tx_sequencer dut (
    .sysclk(sysclk), .reset(reset), .req(req), .auto_en(auto_en), .rom_data(rom_data),
    .tx_busy(tx_busy), .rom_sel(rom_sel), .rom_addr(rom_addr), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .word_done(word_done)
  );

  always #5 sysclk = ~sysclk;
  assign rom_data = {rom_sel, 2'b10, rom_addr};
  assign tx_busy  = mbusy | hold;

  always @(posedge sysclk) begin
    if (tx_start) begin
      mbusy <= 1'b1;
      cnt   <= 10;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) mbusy <= 1'b0;
    end
    if (!reset && tx_start) log_q.push_back({rom_sel, rom_addr, tx_data});
    if (!reset && word_done) n_done <= n_done + 1;
  end

  function automatic int lenw(input int w);
    return w == 0 ? 11 : w == 1 ? 10 : w == 2 ? 7 : 4;
  endfunction

  function automatic logic [31:0] exp_e(input int w, input int i);
    logic [13:0] e;
    e = {w[1:0], i < lenw(w) ? i[3:0] : 4'(lenw(w) - 1),
         i < lenw(w) ? {w[1:0], 2'b10, i[3:0]} : 8'h0D};
    return 32'(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] r);
    @(negedge sysclk) req = r;
    @(negedge sysclk) req = 4'd0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int k = 0;
    while (n_done < target && k < 5000) begin
      @(negedge sysclk);
      k++;
    end
    chk({tag, " done timeout"}, 32'(k < 5000), 32'd1);
  endtask

  task automatic check_words(input string tag, input int w[5], input int nw);
    int idx = 0;
    for (int j = 0; j < nw; j++)
      for (int i = 0; i < lenw(w[j]) + T; i++) begin
        chk({tag, " byte"}, idx < log_q.size() ? 32'(log_q[idx]) : 32'hFFFFFFFF, exp_e(w[j], i));
        idx++;
      end
    chk({tag, " byte count"}, 32'(log_q.size()), 32'(idx));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rom_sel"}, 32'(rom_sel), 32'd0);
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, " tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, " tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " word_done"}, 32'(word_done), 32'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    @(negedge sysclk);
    check_reset_outputs("reset");
    @(negedge sysclk) reset = 1'b0;
    log_q.delete();
    // single word 0 request
    base = n_done;
    pulse(4'b0001);
    wait_done("t1", base + 1);
    ws = '{0, 0, 0, 0, 0};
    check_words("t1", ws, 1);
    chk("t1 busy after", 32'(busy), 32'd0);
    repeat (30) @(negedge sysclk);
    chk("t1 word_done count", 32'(n_done - base), 32'd1);
    chk("t1 no extra bytes", 32'(log_q.size()), 32'(11 + T));
    // two requests in one cycle: word 1 then word 3
    log_q.delete();
    base = n_done;
    pulse(4'b1010);
    wait_done("t2", base + 2);
    ws = '{1, 3, 0, 0, 0};
    check_words("t2", ws, 2);
    // auto cycling, dropped during word 0 of the second lap
    log_q.delete();
    base = n_done;
    @(negedge sysclk) auto_en = 1'b1;
    t = 0;
    while (log_q.size() < 34 + 4 * T && t < 5000) begin
      @(negedge sysclk);
      t++;
    end
    chk("t3 lap timeout", 32'(t < 5000), 32'd1);
    auto_en = 1'b0;
    wait_done("t3", base + 5);
    ws = '{0, 1, 2, 3, 0};
    check_words("t3", ws, 5);
    repeat (40) @(negedge sysclk);
    chk("t3 busy after", 32'(busy), 32'd0);
    chk("t3 stopped", 32'(log_q.size()), 32'(43 + 5 * T));
    // reset in the middle of byte 5
    log_q.delete();
    pulse(4'b0001);
    t = 0;
    while (log_q.size() < 6 && t < 2000) begin
      @(negedge sysclk);
      t++;
    end
    chk("t4 byte5 timeout", 32'(t < 2000), 32'd1);
    repeat (5) @(negedge sysclk);
    chk("t4 tx_busy before reset", 32'(tx_busy), 32'd1);
    chk("t4 busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t4 async");
    @(negedge sysclk) reset = 1'b0;
    log_q.delete();
    base = n_done;
    pulse(4'b0100);
    wait_done("t4", base + 1);
    ws = '{2, 0, 0, 0, 0};
    check_words("t4", ws, 1);
    // transmitter busy for 50 cycles before the first byte
    @(negedge sysclk) reset = 1'b1;
    @(negedge sysclk) reset = 1'b0;
    log_q.delete();
    base = n_done;
    hold = 1'b1;
    pulse(4'b0001);
    repeat (50) @(negedge sysclk);
    chk("t5 start withheld", 32'(log_q.size()), 32'd0);
    chk("t5 busy while held", 32'(busy), 32'd1);
    hold = 1'b0;
    wait_done("t5", base + 1);
    ws = '{0, 0, 0, 0, 0};
    check_words("t5", ws, 1);
    // word 3, with terminator byte when enabled
    log_q.delete();
    base = n_done;
    pulse(4'b1000);
    wait_done("t6", base + 1);
    ws = '{3, 0, 0, 0, 0};
    check_words("t6", ws, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
